// File: rtl/irq_gateway.sv
// Interrupt gateway: per-source level/edge capture into pending bits, lowest-id claim/complete,
// and a registered external_int toward the core. Single-cycle-latency bus responder.
module irq_gateway #(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] src,
   input  logic               sel,
   input  logic               ren,
   input  logic               wen,
   input  logic [1:0]         addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               external_int
);

   localparam logic [1:0] A_PENDING = 2'd0;
   localparam logic [1:0] A_ENABLE  = 2'd1;
   localparam logic [1:0] A_CLAIM   = 2'd2;
   localparam logic [1:0] A_EDGE    = 2'd3;

   logic [NUM_SRC-1:0] pending, enable, edge_trig, in_service, src_q;
   logic [NUM_SRC-1:0] cand, win_oh, clr_oh, cmp_oh, gw_set;
   logic [4:0]         win_idx, cmp_id;
   logic               win_hit, rd_claim, wr_claim;
   logic [31:0]        rd_val;
   logic               unused_wdata;

   assign unused_wdata = ^wdata;
   assign cand     = pending & enable;
   assign rd_claim = sel & ren & (addr == A_CLAIM);
   assign wr_claim = sel & wen & (addr == A_CLAIM);
   assign cmp_id   = wdata[4:0];

   // Descending scan so the lowest-numbered candidate is the last one to win.
   always_comb begin
      win_hit = 1'b0;
      win_idx = '0;
      win_oh  = '0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (cand[i]) begin
            win_hit = 1'b1;
            win_idx = 5'(i);
            win_oh  = '0;
            win_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      cmp_oh = '0;
      for (int i = 0; i < NUM_SRC; i++)
         cmp_oh[i] = wr_claim && (cmp_id == 5'(i+1)) && in_service[i];
   end

   // In-service bits always have pending=0, so the completed bit can never be the claim winner.
   assign clr_oh = (rd_claim && win_hit) ? win_oh : '0;
   assign gw_set = src & ~in_service & ~(edge_trig & src_q);

   always_comb begin
      rd_val = '0;
      case (addr)
         A_PENDING: rd_val[NUM_SRC-1:0] = pending;
         A_ENABLE:  rd_val[NUM_SRC-1:0] = enable;
         A_CLAIM:   rd_val[4:0]         = win_hit ? (win_idx + 5'd1) : 5'd0;
         A_EDGE:    rd_val[NUM_SRC-1:0] = edge_trig;
         default:   rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending      <= '0;
         enable       <= '0;
         edge_trig    <= '0;
         in_service   <= '0;
         src_q        <= '0;
         rdata        <= '0;
         external_int <= 1'b0;
      end else begin
         src_q        <= src;
         pending      <= (pending | gw_set) & ~clr_oh;
         in_service   <= (in_service & ~cmp_oh) | clr_oh;
         external_int <= |cand;
         if (sel && wen && addr == A_ENABLE) enable    <= wdata[NUM_SRC-1:0];
         if (sel && wen && addr == A_EDGE)   edge_trig <= wdata[NUM_SRC-1:0];
         if (sel && ren)                     rdata     <= rd_val;
      end
   end

endmodule
